// File: rtl/text_io_pkg.sv
// Shared types and constants for the processor text-output UART.
package text_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  // Data-address window the program uses for its text buffer.
  localparam int unsigned TEXT_ADDR_LO = 1;
  localparam int unsigned TEXT_ADDR_HI = 21;

  localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output.
// A push while full is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == CW'(0));
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write; the head is read before this edge overwrites a full slot.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at a power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/char_uart_tx.sv
// Snoops byte writes into the text window and sends them out as 8N1 serial frames.
module char_uart_tx
  import text_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_LO      = TEXT_ADDR_LO,
  parameter int unsigned ADDR_HI      = TEXT_ADDR_HI
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWrite,
  input  logic [7:0]                 DataAdr,
  input  logic [7:0]                 WriteData,
  output logic                       tx,
  output logic                       busy,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fill,
  output logic [7:0]                 frames_sent
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  uart_state_t        state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         bit_idx;
  logic [BYTE_W-1:0]  shift;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic               cnt_last;
  logic [BYTE_W-1:0]  head;

  assign cnt_last = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign push     = MemWrite && (DataAdr >= 8'(ADDR_LO)) && (DataAdr <= 8'(ADDR_HI));
  assign pop      = ~empty && ((state == IDLE) || ((state == STOP) && cnt_last));
  assign busy     = (state != IDLE) || ~empty;

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (WriteData),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fill)
  );

  // Sticky flag for a capture lost to a full queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end
  end

  // Serializer: start bit, eight data bits LSB first, stop bit, chaining queued bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tx          <= 1'b1;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      frames_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx  <= 1'b1;
          cnt <= '0;
          if (!empty) begin
            shift <= head;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (cnt_last) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt_last) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[1];
              shift   <= shift >> 1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt_last) begin
            cnt         <= '0;
            frames_sent <= frames_sent + 8'd1;
            if (!empty) begin
              shift <= head;
              tx    <= 1'b0;
              state <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/char_uart_tx.md
# char_uart_tx

Memory-write snooper and UART transmitter for the processor's text output. It watches the data-memory write bus of `top` (MemWrite, DataAdr, WriteData). Every byte stored into the text window is queued in a small FIFO and shifted out on a serial 8N1 line, so the characters the program writes (e.g. "CASA", "MESA", "LIBRO") can be read off a pin on the board or in simulation.

## Interface
Parameters:
- CLKS_PER_BIT, 4: clock cycles per serial bit; must be ≥ 2.
- DEPTH, 8: FIFO entries; must be a power of two.
- ADDR_LO, 1: lowest captured DataAdr, inclusive.
- ADDR_HI, 21: highest captured DataAdr, inclusive.

Ports:
- clk, input, 1: single clock; every register is updated on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- MemWrite, input, 1: processor data-memory write strobe.
- DataAdr, input, 8: processor data address.
- WriteData, input, 8: processor write data.
- tx, output, 1: serial line; idles high.
- busy, output, 1: high when the FSM is not IDLE or the FIFO is not empty.
- overflow, output, 1: sticky; set when a write is dropped because the FIFO is full.
- fill, output, $clog2(DEPTH)+1: current number of FIFO entries.
- frames_sent, output, 8: count of completed frames; wraps from 255 to 0.

## Operation
- Capture: on a clk edge where MemWrite=1 and ADDR_LO ≤ DataAdr ≤ ADDR_HI, push WriteData.
  - MemWrite=0, or an address outside the window, has no effect.
- Full FIFO:
  - A push without a same-edge pop is dropped and sets overflow.
  - A push with a same-edge pop is accepted; fill is unchanged.
- Serializer FSM, states IDLE, START, DATA, STOP:
  - IDLE: tx=1. If fill>0, pop the head into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0]; each bit lasts CLKS_PER_BIT cycles, LSB first. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then increment frames_sent. If fill>0, pop and go directly to START; otherwise go to IDLE.
- Counters:
  - The bit-period counter runs 0..CLKS_PER_BIT-1.
  - The bit index is 3 bits.
  - frames_sent is modulo 256.
- Reset, whether asserted idle or mid-frame, takes effect immediately and asynchronously:
  - state=IDLE, tx=1, FIFO emptied (fill=0), overflow=0, frames_sent=0, busy=0.
  - A partial frame is abandoned and never retransmitted.

## Timing
- tx is a registered output and never glitches.
- A write captured at edge N with the FIFO empty and the FSM idle:
  - tx falls at edge N+1 (pop and IDLE→START on the same edge).
  - The push at N and the pop at N+1 are separate edges; an entry is never popped on the edge that pushes it.
- Frame length is exactly 10·CLKS_PER_BIT cycles.
- Queued frames are sent back-to-back with no extra idle cycles between stop bit and next start bit.
- fill updates on the edge of the push or pop. busy is combinational from state and fill.
- Simultaneous push and pop: both take effect and fill is unchanged (this applies at any fill level, including full).

## Structure
- Package text_io_pkg holds:
  - enum uart_state_t {IDLE, START, DATA, STOP};
  - constants TEXT_ADDR_LO=1 and TEXT_ADDR_HI=21, which are the parameter defaults.
- Sub-module sync_fifo (WIDTH=8, DEPTH):
  - ports: push, pop, din, dout (head, valid when not empty), full, empty, count;
  - pointers wrap modulo DEPTH; asynchronous reset.
- The top level holds the address-window compare, the overflow flag and the serializer FSM.

## Test plan
- Writes of 67, 65, 83, 65 to addresses 1-4, one write every 50 cycles (CLKS_PER_BIT=4):
  - decoded tx frames are 0x43, 0x41, 0x53, 0x41, LSB first, each 40 cycles long;
  - frames_sent=4, busy=0 and tx=1 at the end.
- Writes to addresses 0 and 22, plus a write of 76 to address 9 with MemWrite=0:
  - fill stays 0, tx stays 1, frames_sent=0.
- 10 back-to-back in-window writes, values 1..10, from idle with DEPTH=8:
  - write 1 is popped at once; writes 2-9 fill the FIFO (fill=8);
  - write 10 is dropped and overflow=1;
  - 9 frames are sent, carrying values 1..9, back-to-back in 360 cycles.
- Single write of 77 to address 5:
  - tx=0 on the very next edge;
  - the start bit is exactly 4 cycles, bits read 1,0,1,1,0,0,1,0, and the stop bit is 4 cycles.
- Reset asserted 15 cycles into a frame with 3 entries queued:
  - tx=1, fill=0, frames_sent=0 and overflow=0 without waiting for a clock edge;
  - after release, tx stays 1 and no frame is emitted.
- 256 single writes, each completed before the next:
  - frames_sent wraps to 0 after frame 256; overflow stays 0.
